// File: rtl/uart_rx.sv
// uart_rx: 8-bit odd-parity UART receiver with synchronized input and ack handshake
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE = 19_200
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       Sin,
  input  logic       ReceiveAck,
  output logic       Receive,
  output logic [7:0] Dout,
  output logic       parityErr,
  output logic       frameErr
);
  localparam int BIT_CYCLES = CLK_FREQUENCY / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4, ACK = 3'd5;
  logic          s1, s2;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          par;
  logic          bit_end, half_end;
  assign bit_end = cnt == BIT_LAST;
  assign half_end = cnt == HALF_LAST;
  always_ff @(posedge clk) begin
    if (Reset) begin
      {s2, s1} <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      Receive <= 1'b0;
      Dout <= '0;
      parityErr <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      {s2, s1} <= {s1, Sin};
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!s2) state <= START;
        end
        START: if (half_end) begin
          cnt <= '0;
          state <= s2 ? IDLE : DATA;
        end
        DATA: if (bit_end) begin
          cnt <= '0;
          sh <= {s2, sh[7:1]};
          idx <= idx + 1'b1;
          if (idx == 3'd7) state <= PARITY;
        end
        PARITY: if (bit_end) begin
          cnt <= '0;
          par <= s2;
          state <= STOP;
        end
        STOP: if (bit_end) begin
          cnt <= '0;
          Dout <= sh;
          parityErr <= ~(^sh ^ par);
          frameErr <= ~s2;
          Receive <= 1'b1;
          state <= ACK;
        end
        ACK: begin
          // line activity here is deliberately ignored until the byte is consumed
          cnt <= '0;
          if (ReceiveAck) begin
            Receive <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
